key_poll_master: RTL and testbench
==================================

Name: key_poll_master

Overview:
- Avalon-MM read master that polls a 1-bit key PIO slave's data register (offset 0) at a programmable interval.
- Debounces the sampled bit and presents a clean key level, one-cycle press/release pulses and a press counter to fabric logic.
- It is the initiator side of the key PIO slave interface. It lets hardware consume key input without the Nios processor.

Parameters:
POLL_PERIOD, 50000, clock cycles from the end of one poll to the next read request (>=1)
DEBOUNCE_COUNT, 4, consecutive identical samples required to change key_state (>=1)
READ_LATENCY, 1, cycles from accepted read to valid readdata (the PIO slave registers readdata: 1)
ACTIVE_LOW, 1, 1 = raw bit 0 means pressed

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  1 = polling runs; 0 = no new polls
avm_address  out  2  read address; always 2'd0
avm_read  out  1  read request
avm_waitrequest  in  1  slave stall; tie 0 if the slave has none
avm_readdata  in  32  read data; only bit 0 is used
key_state  out  1  debounced level, 1 = pressed
key_press  out  1  one-cycle pulse on a debounced 0->1 transition
key_release  out  1  one-cycle pulse on a debounced 1->0 transition
sample_valid  out  1  one-cycle pulse each time a sample is captured
press_count  out  16  number of debounced presses; wraps at 65535->0

Behaviour:
- Reset values: state IDLE, poll timer 0, avm_read 0, avm_address 0, key_state 0, all pulses 0, press_count 0, candidate 0 (released), stable count 0.
- IDLE:
  - Timer increments each cycle while enable=1.
  - When timer==POLL_PERIOD-1 and enable=1: timer<=0, go REQ.
  - enable=0: timer is held at 0.
- REQ:
  - avm_read=1, avm_address=0.
  - Stay while avm_waitrequest=1.
  - When waitrequest=0 the read is accepted: go WAIT, latency counter <=1.
- WAIT:
  - avm_read=0.
  - When latency counter==READ_LATENCY, go CAPTURE; else increment the counter.
  - CAPTURE samples avm_readdata in that next cycle.
- CAPTURE (one cycle):
  - s = avm_readdata[0] XOR ACTIVE_LOW.
  - sample_valid pulses on the following cycle.
  - Return to IDLE.
- Debounce, evaluated in CAPTURE:
  - s != candidate: candidate<=s, cnt<=1.
  - s == candidate: cnt<=min(cnt+1, DEBOUNCE_COUNT) (saturates).
  - If the new cnt >= DEBOUNCE_COUNT and s != key_state: key_state<=s on the same edge.
  - Same edge: key_press<=s, key_release<=~s for exactly one cycle.
  - On a press, press_count<=press_count+1, modulo 2^16.
  - DEBOUNCE_COUNT=1 gives an immediate update on every change.
- Pulses, timing and stall rules:
  - key_press and key_release are never asserted together.
  - key_press, key_release and sample_valid are asserted together on the cycle after CAPTURE; they deassert next cycle.
  - Nominal cycles per poll with no stall: POLL_PERIOD (IDLE) + 1 (REQ) + READ_LATENCY (WAIT) + 1 (CAPTURE).
- enable deasserted mid-transaction (REQ/WAIT/CAPTURE):
  - The transaction completes and the sample is used.
  - Then IDLE holds with the timer at 0.
- avm_waitrequest held indefinitely: remains in REQ with avm_read=1; no timeout.
- Reset asserted mid-operation: everything returns to reset values immediately. A pending read is abandoned and its data ignored.
- avm_readdata bits 31:1 are ignored.

Test Plan:
- Reset: assert reset for 3 cycles with readdata=0 -> all outputs 0, avm_read 0, and no read issued while held.
- Poll timing (POLL_PERIOD=4, READ_LATENCY=1, waitrequest=0): release reset -> avm_read high for 1 cycle every 7 cycles, address 0; sample_valid 3 cycles after each read.
- Debounce (DEBOUNCE_COUNT=4, ACTIVE_LOW=1): raw sequence 0,1,0,0,0,0 over successive polls -> key_press exactly once, after the 6th sample; key_state=1; press_count=1. Then raw 1,1,1,1 -> key_release once after the 4th sample.
- Waitrequest stall: waitrequest=1 for 5 cycles during REQ -> avm_read held 5+1 cycles; capture occurs READ_LATENCY+1 cycles after acceptance.
- enable drop: deassert enable in the WAIT cycle -> sample still captured; no further avm_read until enable=1; then the first read comes POLL_PERIOD cycles later.
- Wrap and reset mid-read:
  - Preload 65535 presses (force), then one more press -> press_count=0.
  - Assert reset during REQ -> avm_read drops asynchronously and all outputs are 0.

Source files
------------

// File: rtl/key_poll_master.sv
// Avalon-MM read master that periodically polls a 1-bit key PIO, debounces the
// sampled bit and reports a clean level, press/release pulses and a press count.
module key_poll_master #(
  parameter int unsigned POLL_PERIOD    = 50000,
  parameter int unsigned DEBOUNCE_COUNT = 4,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned ACTIVE_LOW     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  output logic [1:0]  avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        key_state,
  output logic        key_press,
  output logic        key_release,
  output logic        sample_valid,
  output logic [15:0] press_count
);

  localparam int unsigned TIMER_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int unsigned LAT_W   = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;
  localparam int unsigned DB_W    = $clog2(DEBOUNCE_COUNT + 1);
  localparam int unsigned CNT_W   = 16;

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(POLL_PERIOD - 1);
  localparam logic [LAT_W-1:0]   LAT_LAST   = LAT_W'(READ_LATENCY);
  localparam logic [DB_W-1:0]    DB_MAX     = DB_W'(DEBOUNCE_COUNT);
  localparam logic               ACT_LO     = (ACTIVE_LOW != 0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_WAIT    = 2'd2,
    S_CAPTURE = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [LAT_W-1:0]   lat_q, lat_d;
  logic               cand_q, cand_d;
  logic [DB_W-1:0]    db_cnt_q, db_cnt_d;
  logic               key_state_q, key_state_d;
  logic               key_press_q, key_press_d;
  logic               key_release_q, key_release_d;
  logic               sample_valid_q, sample_valid_d;
  logic [CNT_W-1:0]   press_count_q, press_count_d;
  logic               avm_read_q, avm_read_d;

  logic               samp_c;
  logic [DB_W-1:0]    db_next_c;
  logic               rd_unused;

  // Only bit 0 of the PIO data register carries the key; normalise to 1 = pressed.
  assign samp_c    = avm_readdata[0] ^ ACT_LO;
  assign rd_unused = ^avm_readdata[31:1];

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    lat_d          = lat_q;
    cand_d         = cand_q;
    db_cnt_d       = db_cnt_q;
    db_next_c      = db_cnt_q;
    key_state_d    = key_state_q;
    key_press_d    = 1'b0;
    key_release_d  = 1'b0;
    sample_valid_d = 1'b0;
    press_count_d  = press_count_q;

    case (state_q)
      S_IDLE: begin
        if (!enable) begin
          timer_d = '0;
        end else if (timer_q == TIMER_LAST) begin
          timer_d = '0;
          state_d = S_REQ;
        end else begin
          timer_d = timer_q + TIMER_W'(1);
        end
      end
      S_REQ: begin
        if (!avm_waitrequest) begin
          state_d = S_WAIT;
          lat_d   = LAT_W'(1);
        end
      end
      S_WAIT: begin
        if (lat_q == LAT_LAST) begin
          state_d = S_CAPTURE;
        end else begin
          lat_d = lat_q + LAT_W'(1);
        end
      end
      S_CAPTURE: begin
        state_d        = S_IDLE;
        sample_valid_d = 1'b1;
        // A differing sample restarts the run; a matching one extends it up to saturation.
        if (samp_c != cand_q) begin
          cand_d    = samp_c;
          db_next_c = DB_W'(1);
        end else if (db_cnt_q < DB_MAX) begin
          db_next_c = db_cnt_q + DB_W'(1);
        end
        db_cnt_d = db_next_c;
        if ((db_next_c >= DB_MAX) && (samp_c != key_state_q)) begin
          key_state_d   = samp_c;
          key_press_d   = samp_c;
          key_release_d = ~samp_c;
          if (samp_c) begin
            press_count_d = press_count_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign avm_read_d = (state_d == S_REQ);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_IDLE;
      timer_q        <= '0;
      lat_q          <= '0;
      cand_q         <= 1'b0;
      db_cnt_q       <= '0;
      key_state_q    <= 1'b0;
      key_press_q    <= 1'b0;
      key_release_q  <= 1'b0;
      sample_valid_q <= 1'b0;
      press_count_q  <= '0;
      avm_read_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      lat_q          <= lat_d;
      cand_q         <= cand_d;
      db_cnt_q       <= db_cnt_d;
      key_state_q    <= key_state_d;
      key_press_q    <= key_press_d;
      key_release_q  <= key_release_d;
      sample_valid_q <= sample_valid_d;
      press_count_q  <= press_count_d;
      avm_read_q     <= avm_read_d;
    end
  end

  assign avm_address  = 2'd0;
  assign avm_read     = avm_read_q;
  assign key_state    = key_state_q;
  assign key_press    = key_press_q;
  assign key_release  = key_release_q;
  assign sample_valid = sample_valid_q;
  assign press_count  = press_count_q;

endmodule

// File: tb/tb_key_poll_master.sv
// Bench for key_poll_master: scoreboard of expected debounce results keyed to
// accepted reads, a debounce vector table and hand-written corner sequences.
module tb_key_poll_master;

  localparam int unsigned PP = 4;
  localparam int unsigned DC = 4;
  localparam int unsigned RL = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        enable;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        key_state;
  logic        key_press;
  logic        key_release;
  logic        sample_valid;
  logic [15:0] press_count;

  typedef struct packed {
    logic        st;
    logic        pr;
    logic        rl;
    logic [15:0] cnt;
  } exp_t;

  typedef struct packed {
    logic raw;
    exp_t e;
  } vec_t;

  exp_t sb[$];
  int   acc_q[$];
  exp_t cur_exp;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic sv_seen = 1'b0;

  key_poll_master #(
    .POLL_PERIOD   (PP),
    .DEBOUNCE_COUNT(DC),
    .READ_LATENCY  (RL),
    .ACTIVE_LOW    (1)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata   (avm_readdata),
    .key_state      (key_state),
    .key_press      (key_press),
    .key_release    (key_release),
    .sample_valid   (sample_valid),
    .press_count    (press_count)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk_exp(logic st, logic pr, logic rl, logic [15:0] c);
    exp_t e;
    e.st  = st;
    e.pr  = pr;
    e.rl  = rl;
    e.cnt = c;
    return e;
  endfunction

  function automatic vec_t mk_vec(logic raw, logic st, logic pr, logic rl, logic [15:0] c);
    vec_t v;
    v.raw = raw;
    v.e   = mk_exp(st, pr, rl, c);
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Upper data bits are randomised; only bit 0 should matter.
  task automatic drive_raw(input logic r);
    avm_readdata = {31'($urandom), r};
  endtask

  // One clock: accept is judged on the inputs as they stand at the coming edge,
  // outputs are observed at the following falling edge.
  task automatic tick();
    logic pend_acc;
    exp_t e;
    int   a;
    pend_acc = avm_read && !avm_waitrequest && !reset;
    @(negedge clk);
    cyc++;
    if (pend_acc) begin
      sb.push_back(cur_exp);
      acc_q.push_back(cyc - 1);
    end
    if (avm_read) check("addr", 32'(avm_address), 32'd0);
    sv_seen = sample_valid;
    if (sample_valid) begin
      check("press_rel_excl", 32'(key_press & key_release), 32'd0);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_sample actual=1 expected=0 (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        a = acc_q.pop_front();
        check("sample_lat", 32'(cyc), 32'(a + 3));
        check("sample_outs", 32'({key_state, key_press, key_release, press_count}), 32'(e));
      end
    end
  endtask

  task automatic wait_sample(input string name);
    int n;
    n = 0;
    sv_seen = 1'b0;
    while (!sv_seen && n < 40) begin
      tick();
      n++;
    end
    if (!sv_seen) begin
      checks++;
      errors++;
      $display("FAIL %s timeout actual=no_sample expected=sample", name);
    end
  endtask

  task automatic wait_read(input string name);
    int n;
    n = 0;
    while (!avm_read && n < 40) begin
      tick();
      n++;
    end
    if (!avm_read) begin
      checks++;
      errors++;
      $display("FAIL %s timeout actual=no_read expected=read", name);
    end
  endtask

  initial begin
    vec_t tbl[11];
    int   reads_seen;

    reset           = 1'b1;
    enable          = 1'b1;
    avm_waitrequest = 1'b0;
    avm_readdata    = 32'd0;
    cur_exp         = '0;

    // Reset held: nothing issued, all outputs quiet.
    reads_seen = 0;
    repeat (3) begin
      tick();
      if (avm_read) reads_seen++;
    end
    check("rst_outs", 32'({avm_read, key_state, key_press, key_release, sample_valid, press_count}), 32'd0);
    check("rst_noread", 32'(reads_seen), 32'd0);

    // Poll cadence: read every PP+RL+2 cycles, sample RL+2 cycles after the read.
    drive_raw(1'b1);
    reset = 1'b0;
    for (int i = 1; i <= 25; i++) begin
      tick();
      check("poll_read", 32'(avm_read), 32'((i >= 4) && ((i - 4) % 7 == 0)));
      check("poll_sv", 32'(sample_valid), 32'((i >= 7) && ((i - 7) % 7 == 0)));
    end
    wait_sample("poll_tail");

    // Debounce table: raw bit per poll and expected outputs after its capture.
    tbl[0]  = mk_vec(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    tbl[1]  = mk_vec(1'b1, 1'b0, 1'b0, 1'b0, 16'd0);
    tbl[2]  = mk_vec(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    tbl[3]  = mk_vec(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    tbl[4]  = mk_vec(1'b0, 1'b0, 1'b0, 1'b0, 16'd0);
    tbl[5]  = mk_vec(1'b0, 1'b1, 1'b1, 1'b0, 16'd1);
    tbl[6]  = mk_vec(1'b0, 1'b1, 1'b0, 1'b0, 16'd1);
    tbl[7]  = mk_vec(1'b1, 1'b1, 1'b0, 1'b0, 16'd1);
    tbl[8]  = mk_vec(1'b1, 1'b1, 1'b0, 1'b0, 16'd1);
    tbl[9]  = mk_vec(1'b1, 1'b1, 1'b0, 1'b0, 16'd1);
    tbl[10] = mk_vec(1'b1, 1'b0, 1'b0, 1'b1, 16'd1);
    for (int k = 0; k < 11; k++) begin
      drive_raw(tbl[k].raw);
      cur_exp = tbl[k].e;
      wait_sample("debounce");
    end

    // Waitrequest stall: five stalled REQ cycles plus the accepting one.
    avm_waitrequest = 1'b1;
    drive_raw(1'b1);
    cur_exp = mk_exp(1'b0, 1'b0, 1'b0, 16'd1);
    wait_read("stall_wait");
    for (int i = 2; i <= 6; i++) begin
      tick();
      check("stall_hold", 32'(avm_read), 32'd1);
    end
    avm_waitrequest = 1'b0;
    tick();
    check("stall_drop", 32'(avm_read), 32'd0);
    wait_sample("stall_sample");

    // Enable dropped during WAIT: sample still taken, then polling pauses.
    wait_read("en_wait");
    tick();
    check("en_in_wait", 32'(avm_read), 32'd0);
    enable = 1'b0;
    wait_sample("en_sample");
    reads_seen = 0;
    repeat (20) begin
      tick();
      if (avm_read) reads_seen++;
    end
    check("en_idle_noread", 32'(reads_seen), 32'd0);
    enable = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("en_resume", 32'(avm_read), 32'(i == 4));
    end
    wait_sample("en_resume_sample");

    // Press counter wrap from a preloaded 65535.
    force dut.press_count_q = 16'hFFFF;
    tick();
    release dut.press_count_q;
    tick();
    check("wrap_preload", 32'(press_count), 32'h0000_FFFF);
    for (int k = 0; k < 4; k++) begin
      drive_raw(1'b0);
      cur_exp = (k < 3) ? mk_exp(1'b0, 1'b0, 1'b0, 16'hFFFF) : mk_exp(1'b1, 1'b1, 1'b0, 16'd0);
      wait_sample("wrap_sample");
    end

    // Reset in REQ: read drops at once, pending read is abandoned.
    drive_raw(1'b1);
    cur_exp = '0;
    wait_read("rst_wait");
    reset = 1'b1;
    #1;
    check("rst_mid_read", 32'(avm_read), 32'd0);
    check("rst_mid_outs", 32'({key_state, key_press, key_release, sample_valid, press_count}), 32'd0);
    repeat (2) tick();
    reset = 1'b0;
    wait_sample("post_rst_sample");
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
